// File: rtl/main_control_fsm_pkg.sv
// Shared RV32 control definitions: opcodes, funct fields, ALUOp codes,
// FSM state encoding and the instruction class used by the control core.
package main_control_fsm_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BLT  = 3'b100;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_JAL    = 2'b11;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_EXEC    = 4'd2,
    ST_ALU_WB  = 4'd3,
    ST_ADDR    = 4'd4,
    ST_MEM_RD  = 4'd5,
    ST_LOAD_WB = 4'd6,
    ST_MEM_WR  = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_JAL     = 4'd9,
    ST_TRAP    = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE  = 3'd0,
    CLS_ADDI   = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JAL    = 3'd5
  } iclass_t;

endpackage

// File: rtl/instr_classify.sv
// Combinational instruction classifier: maps the latched instruction fields
// to an instruction class plus a legality flag for the supported RV32 subset.
module instr_classify
  import main_control_fsm_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output iclass_t    cls,
  output logic       legal
);

  always_comb begin
    cls   = CLS_RTYPE;
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        cls = CLS_RTYPE;
        // slt/sltu (funct3 01x) are outside the subset, as are sra and other alt forms
        legal = ((funct7 == F7_BASE) && (funct3[2:1] != 2'b01)) ||
                ((funct7 == F7_ALT) && (funct3 == 3'b000));
      end
      OP_IMM: begin
        cls   = CLS_ADDI;
        legal = (funct3 == F3_ADDI);
      end
      OP_LOAD: begin
        cls   = CLS_LOAD;
        legal = (funct3 == F3_LW);
      end
      OP_STORE: begin
        cls   = CLS_STORE;
        legal = (funct3 == F3_SW);
      end
      OP_BRANCH: begin
        cls   = CLS_BRANCH;
        legal = (funct3 == F3_BEQ) || (funct3 == F3_BLT);
      end
      OP_JAL: begin
        cls   = CLS_JAL;
        legal = 1'b1;
      end
      default: begin
        cls   = CLS_RTYPE;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle main control unit for the RV32 subset core: latches an
// instruction over valid/ready and sequences the datapath strobes.
//
// state   | meaning
// FETCH   | ready for a new instruction
// DECODE  | classify latched IR
// EXEC    | R-type / addi ALU operation
// ALU_WB  | write ALU result, PC+4
// ADDR    | load/store address calculation
// MEM_RD  | load request, held until mem_ack
// LOAD_WB | write memory data, PC+4
// MEM_WR  | store request, held until mem_ack
// BRANCH  | compare and conditional PC update
// JAL     | link write and jump
// TRAP    | illegal instruction, stuck until reset
module main_control_fsm
  import main_control_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        mem_ack,
  output logic [1:0]  ALUOp,
  output logic [3:0]  inst,
  output logic        alu_src_b,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        link,
  output logic        mem_read,
  output logic        mem_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        illegal
);

  state_t      state, state_nx;
  logic [31:0] ir;
  iclass_t     cls;
  logic        legal;

  instr_classify u_classify (
    .opcode (ir[6:0]),
    .funct3 (ir[14:12]),
    .funct7 (ir[31:25]),
    .cls    (cls),
    .legal  (legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FETCH;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (instr_valid && instr_ready) ir <= instr;
    end
  end

  assign inst = {ir[30], ir[14:12]};

  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    ALUOp       = ALUOP_ADD;
    alu_src_b   = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    link        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    illegal     = 1'b0;
    case (state)
      ST_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nx = ST_DECODE;
      end
      ST_DECODE: begin
        if (!legal) state_nx = ST_TRAP;
        else begin
          case (cls)
            CLS_RTYPE, CLS_ADDI:  state_nx = ST_EXEC;
            CLS_LOAD, CLS_STORE:  state_nx = ST_ADDR;
            CLS_BRANCH:           state_nx = ST_BRANCH;
            CLS_JAL:              state_nx = ST_JAL;
            default:              state_nx = ST_TRAP;
          endcase
        end
      end
      ST_EXEC: begin
        if (cls == CLS_ADDI) begin
          ALUOp     = ALUOP_ADD;
          alu_src_b = 1'b1;
        end else begin
          ALUOp = ALUOP_RTYPE;
        end
        state_nx = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_nx  = ST_FETCH;
      end
      ST_ADDR: begin
        alu_src_b = 1'b1;
        state_nx  = (cls == CLS_LOAD) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        if (mem_ack) state_nx = ST_LOAD_WB;
      end
      ST_LOAD_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        pc_write   = 1'b1;
        state_nx   = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        pc_write  = mem_ack;
        if (mem_ack) state_nx = ST_FETCH;
      end
      ST_BRANCH: begin
        ALUOp    = ALUOP_BRANCH;
        pc_write = 1'b1;
        // funct3[2] distinguishes blt from beq
        pc_src   = ir[14] ? alu_lt : alu_zero;
        state_nx = ST_FETCH;
      end
      ST_JAL: begin
        ALUOp     = ALUOP_JAL;
        reg_write = 1'b1;
        link      = 1'b1;
        pc_write  = 1'b1;
        pc_src    = 1'b1;
        state_nx  = ST_FETCH;
      end
      ST_TRAP: begin
        illegal  = 1'b1;
        state_nx = ST_TRAP;
      end
      default: state_nx = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed self-checking bench for main_control_fsm.
module tb_main_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        alu_zero;
  logic        alu_lt;
  logic        mem_ack;
  logic [1:0]  ALUOp;
  logic [3:0]  inst;
  logic        alu_src_b;
  logic        reg_write;
  logic        mem_to_reg;
  logic        link;
  logic        mem_read;
  logic        mem_write;
  logic        pc_write;
  logic        pc_src;
  logic        illegal;

  int total = 0;
  int passed = 0;

  main_control_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_zero    (alu_zero),
    .alu_lt      (alu_lt),
    .mem_ack     (mem_ack),
    .ALUOp       (ALUOp),
    .inst        (inst),
    .alu_src_b   (alu_src_b),
    .reg_write   (reg_write),
    .mem_to_reg  (mem_to_reg),
    .link        (link),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // all strobes packed: {illegal,instr_ready,ALUOp,alu_src_b,reg_write,mem_to_reg,link,mem_read,mem_write,pc_write,pc_src}
  function automatic logic [11:0] outs();
    return {illegal, instr_ready, ALUOp, alu_src_b, reg_write, mem_to_reg,
            link, mem_read, mem_write, pc_write, pc_src};
  endfunction

  // issue one instruction in FETCH; returns with the FSM in DECODE
  task automatic issue(input logic [31:0] w);
    instr       = w;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    instr       = 32'hFFFF_FFFF;
  endtask

  int cnt;

  initial begin
    rst = 1'b1; instr = '0; instr_valid = 1'b0;
    alu_zero = 1'b0; alu_lt = 1'b0; mem_ack = 1'b0;
    step(); step();
    chk("reset_outs", 32'(outs()), 32'h400);
    chk("reset_inst", 32'(inst), 32'h0);
    rst = 1'b0;
    step();
    chk("idle_fetch", 32'(outs()), 32'h400);

    // add: DECODE, EXEC, ALU_WB, FETCH; valid in DECODE is ignored
    issue(32'h0020_81B3);
    chk("add_inst", 32'(inst), 32'h0);
    chk("add_decode", 32'(outs()), 32'h000);
    instr = 32'h4020_81B3; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("add_exec", 32'(outs()), 32'h200);
    chk("ir_hold", 32'(inst), 32'h0);
    step();
    chk("add_wb", 32'(outs()), 32'h042);
    step();
    chk("add_back_fetch", 32'(outs()), 32'h400);

    // sub
    issue(32'h4020_81B3);
    chk("sub_inst", 32'(inst), 32'h8);
    step();
    chk("sub_exec", 32'(outs()), 32'h200);
    step(); step();
    chk("sub_fetch", 32'(instr_ready), 32'h1);

    // addi x1,x1,8
    issue(32'h0080_8093);
    step();
    chk("addi_exec", 32'(outs()), 32'h080);
    step();
    chk("addi_wb", 32'(outs()), 32'h042);
    step();

    // lw with ack on the 4th MEM_RD cycle; ack during ADDR must be ignored
    issue(32'h0080_A283);
    chk("lw_inst", 32'(inst), 32'h2);
    step();
    mem_ack = 1'b1;
    chk("lw_addr", 32'(outs()), 32'h080);
    step();
    mem_ack = 1'b0;
    cnt = 0;
    while (mem_read && cnt < 10) begin
      cnt++;
      mem_ack = (cnt == 4);
      #1;
      chk("lw_rd_nopc", 32'(pc_write), 32'h0);
      step();
    end
    mem_ack = 1'b0;
    chk("lw_read_cycles", 32'(cnt), 32'd4);
    chk("lw_wb", 32'(outs()), 32'h062);
    step();
    chk("lw_fetch", 32'(outs()), 32'h400);

    // sw, immediate ack
    issue(32'h0050_A423);
    step();
    chk("sw_addr", 32'(outs()), 32'h080);
    step();
    mem_ack = 1'b1;
    #1;
    chk("sw_memwr", 32'(outs()), 32'h006);
    step();
    mem_ack = 1'b0;
    chk("sw_fetch", 32'(outs()), 32'h400);

    // sw with one wait state: pc_write only in the ack cycle
    issue(32'h0050_A423);
    step(); step();
    chk("sw_wait", 32'(outs()), 32'h004);
    step();
    mem_ack = 1'b1;
    #1;
    chk("sw_ack", 32'(outs()), 32'h006);
    step();
    mem_ack = 1'b0;
    chk("sw2_fetch", 32'(instr_ready), 32'h1);

    // beq taken, then flip alu_zero inside BRANCH
    alu_zero = 1'b1; alu_lt = 1'b0;
    issue(32'h0020_8463);
    step();
    chk("beq_taken", 32'(outs()), 32'h103);
    alu_zero = 1'b0;
    #1;
    chk("beq_not_taken", 32'(outs()), 32'h102);
    step();
    chk("beq_fetch", 32'(outs()), 32'h400);

    // blt: alu_lt=0, alu_zero=1 -> not taken; alu_lt=1 -> taken
    alu_zero = 1'b1; alu_lt = 1'b0;
    issue(32'h0020_C463);
    chk("blt_inst", 32'(inst), 32'h4);
    step();
    chk("blt_not_taken", 32'(outs()), 32'h102);
    alu_lt = 1'b1;
    #1;
    chk("blt_taken", 32'(outs()), 32'h103);
    step();
    alu_zero = 1'b0; alu_lt = 1'b0;

    // jal x1,16
    issue(32'h0100_00EF);
    step();
    chk("jal", 32'(outs()), 32'h353);
    step();
    chk("jal_fetch", 32'(outs()), 32'h400);

    // reset during MEM_RD
    issue(32'h0080_A283);
    step(); step();
    chk("rd_before_rst", 32'(mem_read), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_outs", 32'(outs()), 32'h400);
    chk("rst_ir_clear", 32'(inst), 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_fetch", 32'(outs()), 32'h400);

    // slt traps and stays trapped despite valid instructions
    issue(32'h0020_A1B3);
    step();
    chk("slt_trap", 32'(outs()), 32'h800);
    instr = 32'h0020_81B3; instr_valid = 1'b1;
    step(); step(); step();
    instr_valid = 1'b0;
    chk("trap_sticky", 32'(outs()), 32'h800);
    rst = 1'b1;
    #1;
    chk("trap_cleared", 32'(outs()), 32'h400);
    step();
    rst = 1'b0;
    step();

    // sra (funct7 0100000, funct3 101) is illegal
    issue(32'h4020_D1B3);
    step();
    chk("sra_trap", 32'(illegal), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
